// File: rtl/neuron_timestep_controller.sv
// rtl/neuron_timestep_controller.sv - LIF timestep sequencer driving one potential adder
module neuron_timestep_controller #(
    parameter int NEURONS     = 30,
    parameter int ADDER_LAT   = 1,
    parameter int DECAY_SHIFT = 1,
    parameter int AW          = $clog2(NEURONS)
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [NEURONS-1:0] spike_vector,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [31:0]        cfg_data,
    output logic               weight_rd,
    output logic [AW-1:0]      weight_addr,
    input  logic [31:0]        weight_data,
    output logic               clear_adder,
    output logic               set_adder,
    output logic [31:0]        input_weight,
    output logic [31:0]        decayed_potential,
    input  logic [31:0]        final_potential,
    input  logic               spike
);

    localparam int CW = (ADDER_LAT < 2) ? 1 : $clog2(ADDER_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SET, S_RD, S_ISSUE, S_WAIT, S_CAP, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q;
    logic [CW-1:0]      cnt_q;
    logic [31:0]        pot_q [NEURONS];
    logic [NEURONS-1:0] spike_q;
    logic [31:0]        weight_q;
    logic [31:0]        decayed_q;
    logic               last_neuron;
    logic               cfg_hit;

    // Leak by exponent subtraction; Inf/NaN pass through, anything that would underflow flushes to +0.
    function automatic logic [31:0] decay(input logic [31:0] x);
        logic [7:0] e;
        e = x[30:23];
        if (DECAY_SHIFT == 0 || e == 8'hFF) begin
            decay = x;
        end else if (e <= 8'(DECAY_SHIFT)) begin
            decay = 32'h0000_0000;
        end else begin
            decay = {x[31], e - 8'(DECAY_SHIFT), x[22:0]};
        end
    endfunction

    assign last_neuron = (idx_q == AW'(NEURONS - 1));
    assign cfg_hit     = cfg_we && (32'(cfg_addr) < 32'(NEURONS));

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode for the per-neuron read / issue / wait / capture loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR:   state_d = S_SET;
            S_SET:   state_d = S_RD;
            S_RD:    state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (cnt_q == CW'(1)) state_d = S_CAP;
            S_CAP:   state_d = last_neuron ? S_DONE : S_RD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs decoded straight from state so none of them depend on inputs.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        clear_adder = 1'b0;
        set_adder   = 1'b0;
        weight_rd   = 1'b0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        clear_adder = (state_q == S_CLR);
        set_adder   = (state_q == S_SET);
        weight_rd   = (state_q == S_RD);
    end

    assign weight_addr       = idx_q;
    assign spike_vector      = spike_q;
    assign input_weight      = weight_q;
    assign decayed_potential = decayed_q;

    // Neuron index and adder latency counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            if (state_q == S_SET) begin
                idx_q <= '0;
            end else if (state_q == S_CAP && !last_neuron) begin
                idx_q <= idx_q + AW'(1);
            end
            if (state_q == S_ISSUE) begin
                cnt_q <= CW'(ADDER_LAT);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // Adder operand registers, held from the cycle after ISSUE until the next ISSUE.
    always_ff @(posedge CLK) begin
        if (reset) begin
            weight_q  <= '0;
            decayed_q <= '0;
        end else if (state_q == S_ISSUE) begin
            weight_q  <= weight_data;
            decayed_q <= decay(pot_q[idx_q]);
        end
    end

    // Potential store: host preload while idle, adder write-back at capture.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NEURONS; i++) begin
                pot_q[i] <= '0;
            end
        end else if (state_q == S_IDLE && cfg_hit) begin
            pot_q[cfg_addr] <= cfg_data;
        end else if (state_q == S_CAP) begin
            pot_q[idx_q] <= final_potential;
        end
    end

    // Per-timestep spike vector, cleared at SET and held after DONE.
    always_ff @(posedge CLK) begin
        if (reset) begin
            spike_q <= '0;
        end else if (state_q == S_SET) begin
            spike_q <= '0;
        end else if (state_q == S_CAP) begin
            spike_q[idx_q] <= spike;
        end
    end

endmodule
